// File: rtl/reg_file_sb.sv
// Two-read/one-write register file with a per-register pending-write counter for RAW stalls.
// Define REGFILE_BYPASS_EN to forward DataIn to same-cycle reads of the register being written.
module reg_file_sb #(
   parameter int WIDTH     = 16,
   parameter int DEPTH     = 8,
   parameter int AW        = $clog2(DEPTH),
   parameter int CNT_W     = 2,
   parameter int ZERO_REG0 = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [AW-1:0]    ReadSelS,
   input  logic [AW-1:0]    ReadSelT,
   input  logic             ReadEnS,
   input  logic             ReadEnT,
   input  logic [AW-1:0]    WrSel,
   input  logic             WrRegEn,
   input  logic [WIDTH-1:0] DataIn,
   input  logic             IssueEn,
   input  logic [AW-1:0]    IssueSel,
   output logic [WIDTH-1:0] Rs,
   output logic [WIDTH-1:0] Rt,
   output logic             BusyS,
   output logic             BusyT,
   output logic             IssueFull,
   output logic             Stall
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic [WIDTH-1:0] regs [DEPTH];
   logic [CNT_W-1:0] cnt  [DEPTH];

   function automatic logic is_zero(input logic [AW-1:0] sel);
      return (ZERO_REG0 != 0) && (sel == '0);
   endfunction

   logic issue_dec;
   logic issue_ok;
   logic wr_ok;

   // A retire on the same register frees a slot, so a full counter can still accept this issue.
   assign issue_dec = WrRegEn && (WrSel == IssueSel) && (cnt[IssueSel] != '0);
   assign IssueFull = (cnt[IssueSel] == CNT_MAX) && !issue_dec && !is_zero(IssueSel);
   assign issue_ok  = IssueEn && !IssueFull && !is_zero(IssueSel);
   assign wr_ok     = WrRegEn && !is_zero(WrSel);

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int r = 0; r < DEPTH; r++) begin
            regs[r] <= '0;
            cnt[r]  <= '0;
         end
      end else begin
         if (wr_ok)
            regs[WrSel] <= DataIn;
         for (int r = 0; r < DEPTH; r++) begin
            logic inc;
            logic dec;
            inc = issue_ok && (IssueSel == AW'(r));
            dec = wr_ok && (WrSel == AW'(r)) && (cnt[r] != '0);
            if (inc && !dec)
               cnt[r] <= cnt[r] + CNT_ONE;
            else if (dec && !inc)
               cnt[r] <= cnt[r] - CNT_ONE;
         end
      end
   end

   logic [WIDTH-1:0] rs_store;
   logic [WIDTH-1:0] rt_store;
   logic             cnt_nz_s;
   logic             cnt_nz_t;

   assign rs_store = is_zero(ReadSelS) ? '0 : regs[ReadSelS];
   assign rt_store = is_zero(ReadSelT) ? '0 : regs[ReadSelT];
   assign cnt_nz_s = (cnt[ReadSelS] != '0) && !is_zero(ReadSelS);
   assign cnt_nz_t = (cnt[ReadSelT] != '0) && !is_zero(ReadSelT);

`ifdef REGFILE_BYPASS_EN
   logic hit_s;
   logic hit_t;

   assign hit_s = wr_ok && (WrSel == ReadSelS);
   assign hit_t = wr_ok && (WrSel == ReadSelT);
   assign Rs    = hit_s ? DataIn : rs_store;
   assign Rt    = hit_t ? DataIn : rt_store;
   // The last outstanding write landing now satisfies the read.
   assign BusyS = cnt_nz_s && !(hit_s && (cnt[ReadSelS] == CNT_ONE));
   assign BusyT = cnt_nz_t && !(hit_t && (cnt[ReadSelT] == CNT_ONE));
`else
   assign Rs    = rs_store;
   assign Rt    = rt_store;
   assign BusyS = cnt_nz_s;
   assign BusyT = cnt_nz_t;
`endif

   assign Stall = (BusyS && ReadEnS) || (BusyT && ReadEnT) || (IssueEn && IssueFull);

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed table-driven bench for reg_file_sb, plus a ZERO_REG0=1 instance.
module tb_reg_file_sb;

`ifdef REGFILE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   typedef struct {
      logic        rst;
      logic [2:0]  ss, st;
      logic        es, et, wen;
      logic [2:0]  ws;
      logic [15:0] din;
      logic        ien;
      logic [2:0]  isel;
      logic [15:0] rs, rt;
      logic        bs, bt, full, stall;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst, es, et, wen, ien;
   logic [2:0]  ss, st, ws, isel;
   logic [15:0] din, rs, rt;
   logic        bs, bt, full, stall;

   logic        z_rst, z_es, z_et, z_wen, z_ien;
   logic [2:0]  z_ss, z_st, z_ws, z_isel;
   logic [15:0] z_din, z_rs, z_rt;
   logic        z_bs, z_bt, z_full, z_stall;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   reg_file_sb dut (
      .clk(clk), .rst(rst), .ReadSelS(ss), .ReadSelT(st), .ReadEnS(es), .ReadEnT(et),
      .WrSel(ws), .WrRegEn(wen), .DataIn(din), .IssueEn(ien), .IssueSel(isel),
      .Rs(rs), .Rt(rt), .BusyS(bs), .BusyT(bt), .IssueFull(full), .Stall(stall)
   );

   reg_file_sb #(.ZERO_REG0(1)) dut_z (
      .clk(clk), .rst(z_rst), .ReadSelS(z_ss), .ReadSelT(z_st), .ReadEnS(z_es), .ReadEnT(z_et),
      .WrSel(z_ws), .WrRegEn(z_wen), .DataIn(z_din), .IssueEn(z_ien), .IssueSel(z_isel),
      .Rs(z_rs), .Rt(z_rt), .BusyS(z_bs), .BusyT(z_bt), .IssueFull(z_full), .Stall(z_stall)
   );

   task automatic chk(input string name, input int idx, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
      end
   endtask

   function automatic vec_t mk(
      input logic r, input logic [2:0] s_s, input logic [2:0] s_t, input logic e_s, input logic e_t,
      input logic w, input logic [2:0] w_s, input logic [15:0] d, input logic i, input logic [2:0] i_s,
      input logic [15:0] x_rs, input logic [15:0] x_rt, input logic x_bs, input logic x_bt,
      input logic x_full, input logic x_stall);
      vec_t v;
      v.rst = r; v.ss = s_s; v.st = s_t; v.es = e_s; v.et = e_t; v.wen = w; v.ws = w_s;
      v.din = d; v.ien = i; v.isel = i_s; v.rs = x_rs; v.rt = x_rt; v.bs = x_bs; v.bt = x_bt;
      v.full = x_full; v.stall = x_stall;
      return v;
   endfunction

   task automatic idle_main();
      rst = 0; ss = 0; st = 0; es = 0; et = 0; wen = 0; ws = 0; din = 0; ien = 0; isel = 0;
   endtask

   task automatic idle_z();
      z_rst = 0; z_ss = 0; z_st = 0; z_es = 0; z_et = 0; z_wen = 0; z_ws = 0; z_din = 0;
      z_ien = 0; z_isel = 0;
   endtask

   vec_t vq[$];

   initial begin
      //            rst ss st es et wen ws din      ien isel | rs                  rt                  bs      bt      full stall
      vq.push_back(mk(0, 3, 0, 0, 0, 1, 3, 16'hBEEF, 0, 0, BYP ? 16'hBEEF : 16'h0, 16'h0, 0, 0, 0, 0));
      vq.push_back(mk(1, 3, 0, 0, 0, 0, 0, 16'h0,    0, 0, 16'hBEEF, 16'h0, 0, 0, 0, 0));
      vq.push_back(mk(0, 3, 0, 1, 0, 0, 0, 16'h0,    0, 0, 16'h0, 16'h0, 0, 0, 0, 0));
      vq.push_back(mk(0, 5, 5, 0, 0, 1, 5, 16'h1234, 0, 0, BYP ? 16'h1234 : 16'h0, BYP ? 16'h1234 : 16'h0, 0, 0, 0, 0));
      vq.push_back(mk(0, 5, 5, 0, 0, 0, 0, 16'h0,    0, 0, 16'h1234, 16'h1234, 0, 0, 0, 0));
      vq.push_back(mk(0, 2, 0, 1, 0, 0, 0, 16'h0,    1, 2, 16'h0, 16'h0, 0, 0, 0, 0));
      vq.push_back(mk(0, 2, 0, 1, 0, 0, 0, 16'h0,    0, 0, 16'h0, 16'h0, 1, 0, 0, 1));
      vq.push_back(mk(0, 2, 0, 1, 0, 1, 2, 16'h00AA, 0, 0, BYP ? 16'h00AA : 16'h0, 16'h0, !BYP, 0, 0, !BYP));
      vq.push_back(mk(0, 2, 0, 1, 0, 0, 0, 16'h0,    0, 0, 16'h00AA, 16'h0, 0, 0, 0, 0));
      vq.push_back(mk(0, 0, 4, 0, 0, 0, 0, 16'h0,    1, 4, 16'h0, 16'h0, 0, 0, 0, 0));
      vq.push_back(mk(0, 0, 4, 0, 0, 0, 0, 16'h0,    1, 4, 16'h0, 16'h0, 0, 1, 0, 0));
      vq.push_back(mk(0, 0, 4, 0, 0, 0, 0, 16'h0,    1, 4, 16'h0, 16'h0, 0, 1, 0, 0));
      vq.push_back(mk(0, 0, 4, 0, 1, 0, 0, 16'h0,    1, 4, 16'h0, 16'h0, 0, 1, 1, 1));
      vq.push_back(mk(0, 0, 4, 0, 0, 1, 4, 16'h4444, 1, 4, 16'h0, BYP ? 16'h4444 : 16'h0, 0, 1, 0, 0));
      vq.push_back(mk(0, 0, 4, 0, 0, 0, 0, 16'h0,    0, 4, 16'h0, 16'h4444, 0, 1, 1, 0));
      vq.push_back(mk(0, 0, 4, 0, 0, 1, 4, 16'h0001, 0, 0, 16'h0, BYP ? 16'h0001 : 16'h4444, 0, 1, 0, 0));
      vq.push_back(mk(0, 0, 4, 0, 0, 1, 4, 16'h0002, 0, 0, 16'h0, BYP ? 16'h0002 : 16'h0001, 0, 1, 0, 0));
      vq.push_back(mk(0, 0, 4, 0, 0, 1, 4, 16'h0003, 0, 0, 16'h0, BYP ? 16'h0003 : 16'h0002, 0, !BYP, 0, 0));
      vq.push_back(mk(0, 0, 4, 0, 0, 0, 0, 16'h0,    0, 0, 16'h0, 16'h0003, 0, 0, 0, 0));
      vq.push_back(mk(0, 6, 6, 0, 0, 1, 6, 16'h0666, 0, 0, BYP ? 16'h0666 : 16'h0, BYP ? 16'h0666 : 16'h0, 0, 0, 0, 0));
      vq.push_back(mk(0, 6, 0, 1, 0, 0, 0, 16'h0,    0, 0, 16'h0666, 16'h0, 0, 0, 0, 0));
      vq.push_back(mk(0, 1, 0, 0, 0, 0, 0, 16'h0,    1, 1, 16'h0, 16'h0, 0, 0, 0, 0));
      vq.push_back(mk(0, 1, 0, 1, 0, 1, 1, 16'h0111, 1, 1, BYP ? 16'h0111 : 16'h0, 16'h0, !BYP, 0, 0, !BYP));
      vq.push_back(mk(0, 1, 0, 1, 0, 0, 0, 16'h0,    0, 0, 16'h0111, 16'h0, 1, 0, 0, 1));
      vq.push_back(mk(1, 1, 0, 0, 0, 0, 0, 16'h0,    1, 1, 16'h0111, 16'h0, 1, 0, 0, 0));
      vq.push_back(mk(0, 1, 5, 1, 1, 0, 0, 16'h0,    0, 0, 16'h0, 16'h0, 0, 0, 0, 0));
      vq.push_back(mk(0, 0, 7, 0, 0, 0, 0, 16'h0,    1, 7, 16'h0, 16'h0, 0, 0, 0, 0));
      vq.push_back(mk(0, 0, 7, 0, 0, 0, 0, 16'h0,    0, 0, 16'h0, 16'h0, 0, 1, 0, 0));
      vq.push_back(mk(0, 0, 7, 0, 1, 0, 0, 16'h0,    0, 0, 16'h0, 16'h0, 0, 1, 0, 1));

      idle_main(); idle_z();
      rst = 1; z_rst = 1;
      @(posedge clk); #1;
      rst = 0; z_rst = 0;

      foreach (vq[i]) begin
         rst = vq[i].rst; ss = vq[i].ss; st = vq[i].st; es = vq[i].es; et = vq[i].et;
         wen = vq[i].wen; ws = vq[i].ws; din = vq[i].din; ien = vq[i].ien; isel = vq[i].isel;
         #3;
         chk("Rs", i, rs, vq[i].rs);
         chk("Rt", i, rt, vq[i].rt);
         chk("BusyS", i, 16'(bs), 16'(vq[i].bs));
         chk("BusyT", i, 16'(bt), 16'(vq[i].bt));
         chk("IssueFull", i, 16'(full), 16'(vq[i].full));
         chk("Stall", i, 16'(stall), 16'(vq[i].stall));
         @(posedge clk); #1;
      end
      idle_main();

      // Zero register: writes and issues to r0 have no effect, even with forwarding.
      z_wen = 1; z_ws = 0; z_din = 16'hFFFF; z_ien = 1; z_isel = 0; z_ss = 0; z_es = 1;
      #3;
      chk("z_Rs_wr", 0, z_rs, 16'h0);
      chk("z_BusyS_wr", 0, 16'(z_bs), 16'h0);
      chk("z_Full_wr", 0, 16'(z_full), 16'h0);
      chk("z_Stall_wr", 0, 16'(z_stall), 16'h0);
      @(posedge clk); #1;
      z_wen = 0; z_st = 0; z_et = 1;
      #3;
      chk("z_Rs", 1, z_rs, 16'h0);
      chk("z_Rt", 1, z_rt, 16'h0);
      chk("z_BusyS", 1, 16'(z_bs), 16'h0);
      chk("z_BusyT", 1, 16'(z_bt), 16'h0);
      chk("z_Stall", 1, 16'(z_stall), 16'h0);
      @(posedge clk); #1;
      idle_z();
      z_wen = 1; z_ws = 1; z_din = 16'hABCD; z_st = 1;
      #3;
      chk("z_Rt_r1_wr", 2, z_rt, BYP ? 16'hABCD : 16'h0);
      @(posedge clk); #1;
      z_wen = 0;
      #3;
      chk("z_Rt_r1", 3, z_rt, 16'hABCD);
      @(posedge clk); #1;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/reg_file_sb.md
# reg_file_sb

Parametrised multi-port CPU register file with an integrated per-register pending-write scoreboard. It is the next-generation register file for the CPU datapath. It provides two combinational read ports and one synchronous write port, and tracks outstanding writebacks per register so decode can stall on RAW hazards. Optional write-to-read forwarding is compiled in by macro.

## Interface
Parameters:
- WIDTH, 16, data width of each register
- DEPTH, 8, number of registers (power of two, ≥2)
- AW, $clog2(DEPTH), register select width
- CNT_W, 2, width of per-register pending counter (max outstanding = 2^CNT_W − 1)
- ZERO_REG0, 0, when 1 register 0 reads as zero, ignores writes and issues, never busy

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous active-high reset
- ReadSelS  in  AW  read port S register select
- ReadSelT  in  AW  read port T register select
- ReadEnS  in  1  port S operand used this cycle (hazard qualification)
- ReadEnT  in  1  port T operand used this cycle
- WrSel  in  AW  writeback register select
- WrRegEn  in  1  writeback strobe; writes DataIn and retires one pending write
- DataIn  in  WIDTH  writeback data
- IssueEn  in  1  instruction issued with destination IssueSel; adds one pending write
- IssueSel  in  AW  issued destination register
- Rs  out  WIDTH  port S read data
- Rt  out  WIDTH  port T read data
- BusyS  out  1  port S register has a pending write not satisfied this cycle
- BusyT  out  1  port T equivalent
- IssueFull  out  1  IssueSel counter saturated; issue will be dropped
- Stall  out  1  (BusyS & ReadEnS) | (BusyT & ReadEnT) | (IssueEn & IssueFull)

## Operation
- Storage: DEPTH × WIDTH flops, cnt[DEPTH] × CNT_W flops.
- Write: WrRegEn=1 → reg[WrSel] ← DataIn at edge.
- Read: Rs = reg[ReadSelS], Rt = reg[ReadSelT], combinational; both ports may select the same register.
- Counter update per register r, with inc = IssueEn & IssueSel==r & ~IssueFull and dec = WrRegEn & WrSel==r & cnt[r]!=0:
  - inc & ~dec → +1
  - dec & ~inc → −1
  - both or neither → unchanged
- WrRegEn to a register with cnt==0: data still written, counter stays 0 (no underflow).
- IssueFull = cnt[IssueSel] == 2^CNT_W−1 and ~dec on IssueSel this cycle. A dropped issue leaves state unchanged and asserts Stall, so decode must hold and retry.
- BusyX = cnt[ReadSelX] != 0, except when bypass applies (see Configuration).
- ZERO_REG0=1: reg[0] is never written, Rs/Rt = 0 when selecting 0, cnt[0] held 0, BusyX=0 and IssueFull=0 for select 0.

## Timing
- Reset: rst=1 at an edge clears all registers and counters. After that edge Rs=Rt=0, BusyS=BusyT=0, IssueFull=0, Stall=0.
- rst has priority over simultaneous WrRegEn/IssueEn; a reset mid-operation discards all pending writes.
- Write latency without bypass: DataIn is visible on Rs/Rt the cycle after WrRegEn.
- Scoreboard latency: issue at edge N gives Busy=1 from cycle N+1. A writeback at edge M clears Busy from M+1 if the count reaches 0.
- No handshake beyond Stall. Stall is purely combinational from the current state and inputs.

## Configuration
- REGFILE_BYPASS_EN defined:
  - When WrRegEn & WrSel==ReadSelX (and not the zero register), RX = DataIn in the same cycle.
  - BusyX is forced 0 if cnt[ReadSelX]==1 for that register.
  - Adds a combinational DataIn → Rs/Rt path.
- Undefined: reads return stored values only; Busy follows the counter only.

## Test plan
- Reset then read: write 0xBEEF to r3, assert rst one cycle, set ReadSelS=3 → Rs=0x0000, BusyS=0, Stall=0.
- Write/read with bypass off: WrSel=5, DataIn=0x1234, ReadSelS=ReadSelT=5 → Rs=Rt=old value that cycle, 0x1234 next cycle. With bypass on → 0x1234 the same cycle.
- Scoreboard RAW: IssueEn on r2, next cycle ReadSelS=2 with ReadEnS=1 → BusyS=1 and Stall=1. Then WrRegEn on r2 with 0x00AA → BusyS=0 the next cycle (bypass on: the same cycle), Rs=0x00AA.
- Saturation: CNT_W=2, issue r4 three times → IssueFull=1. A fourth issue → Stall=1 and cnt stays 3. Simultaneous issue and writeback on r4 → accepted, cnt stays 3.
- Underflow and simultaneity: WrRegEn on r6 with cnt=0 → data written, cnt stays 0. Issue and write of r1 in the same cycle with cnt=1 → cnt stays 1, BusyS stays 1 without bypass.
- ZERO_REG0=1: write 0xFFFF to r0 and issue r0 → Rs=0, BusyS=0, Stall=0.
